// File: rtl/tictactoe_game_ctrl.sv
// tictactoe_game_ctrl: 3x3 tic-tac-toe game sequencer.
// Validates and stores moves, alternates turns, detects win/draw.
// Optional feature macro: TURN_TIMEOUT_EN (per-turn move timeout).
// Ports: CLK, RST (async, active high); new_game, move_valid, move_cell in;
//   move_ready, move_ack, move_err, board, turn, game_state, win_line out.
// All outputs are registered.
module tictactoe_game_ctrl #(
   parameter logic        FIRST_PLAYER   = 1'b0,
   parameter int unsigned TIMEOUT_CYCLES = 500_000_000
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        new_game,
   input  logic        move_valid,
   input  logic [3:0]  move_cell,
   output logic        move_ready,
   output logic        move_ack,
   output logic        move_err,
   output logic [17:0] board,
   output logic        turn,
   output logic [1:0]  game_state,
   output logic [3:0]  win_line
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WAIT  = 2'd1,
      S_CHECK = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   // Cells of each of the 8 lines: rows, columns, diagonal, anti-diagonal.
   localparam logic [3:0] LA [8] = '{4'd0, 4'd3, 4'd6, 4'd0,
                                     4'd1, 4'd2, 4'd0, 4'd2};
   localparam logic [3:0] LB [8] = '{4'd1, 4'd4, 4'd7, 4'd3,
                                     4'd4, 4'd5, 4'd4, 4'd4};
   localparam logic [3:0] LC [8] = '{4'd2, 4'd5, 4'd8, 4'd6,
                                     4'd7, 4'd8, 4'd8, 4'd6};

   state_t      state_q, state_d;
   logic [17:0] board_q, board_d;
   logic        turn_q, turn_d;
   logic [1:0]  gs_q, gs_d;
   logic [3:0]  wl_q, wl_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        ready_q, ready_d;
   logic        ack_q, ack_d;
   logic        err_q, err_d;

`ifdef TURN_TIMEOUT_EN
   localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
   logic [31:0] tmo_q, tmo_d;
`else
   logic unused_tmo;
   assign unused_tmo = ^TIMEOUT_CYCLES;
`endif

   logic [1:0] mark;
   logic       mv_in;
   logic [1:0] mv_cell;
   logic       win_hit;
   logic [3:0] win_idx;

   // Encoding of the current mover: X=01, O=10.
   assign mark  = {turn_q, ~turn_q};
   assign mv_in = (move_cell <= 4'd8);

   always_comb begin
      mv_cell = 2'b00;
      if (mv_in) mv_cell = board_q[{move_cell, 1'b0} +: 2];
   end

   // Scan from the top so the lowest complete line index wins.
   always_comb begin
      win_hit = 1'b0;
      win_idx = 4'hF;
      for (int l = 7; l >= 0; l--) begin
         if (board_q[{LA[l], 1'b0} +: 2] == mark &&
             board_q[{LB[l], 1'b0} +: 2] == mark &&
             board_q[{LC[l], 1'b0} +: 2] == mark) begin
            win_hit = 1'b1;
            win_idx = 4'(l);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      board_d = board_q;
      turn_d  = turn_q;
      gs_d    = gs_q;
      wl_d    = wl_q;
      cnt_d   = cnt_q;
      ack_d   = 1'b0;
      err_d   = 1'b0;
`ifdef TURN_TIMEOUT_EN
      tmo_d   = 32'd0;
`endif
      if (new_game) begin
         state_d = S_WAIT;
         board_d = '0;
         turn_d  = FIRST_PLAYER;
         gs_d    = 2'b00;
         wl_d    = 4'hF;
         cnt_d   = 4'd0;
      end else begin
         unique case (state_q)
            S_IDLE: ;
            S_WAIT: begin
               if (move_valid) begin
                  if (mv_in && mv_cell == 2'b00) begin
                     board_d[{move_cell, 1'b0} +: 2] = mark;
                     cnt_d   = cnt_q + 4'd1;
                     ack_d   = 1'b1;
                     state_d = S_CHECK;
                  end else begin
                     err_d = 1'b1;
                  end
               end
`ifdef TURN_TIMEOUT_EN
               else if (tmo_q == TMO_LAST) begin
                  turn_d = ~turn_q;
               end else begin
                  tmo_d = tmo_q + 32'd1;
               end
`endif
            end
            S_CHECK: begin
               if (win_hit) begin
                  gs_d    = turn_q ? 2'b10 : 2'b01;
                  wl_d    = win_idx;
                  state_d = S_DONE;
               end else if (cnt_q == 4'd9) begin
                  gs_d    = 2'b11;
                  wl_d    = 4'hF;
                  state_d = S_DONE;
               end else begin
                  turn_d  = ~turn_q;
                  state_d = S_WAIT;
               end
            end
            S_DONE: ;
            default: state_d = S_IDLE;
         endcase
      end
      ready_d = (state_d == S_WAIT);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= S_IDLE;
         board_q <= '0;
         turn_q  <= FIRST_PLAYER;
         gs_q    <= 2'b00;
         wl_q    <= 4'hF;
         cnt_q   <= 4'd0;
         ready_q <= 1'b0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
`ifdef TURN_TIMEOUT_EN
         tmo_q   <= 32'd0;
`endif
      end else begin
         state_q <= state_d;
         board_q <= board_d;
         turn_q  <= turn_d;
         gs_q    <= gs_d;
         wl_q    <= wl_d;
         cnt_q   <= cnt_d;
         ready_q <= ready_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
`ifdef TURN_TIMEOUT_EN
         tmo_q   <= tmo_d;
`endif
      end
   end

   assign move_ready = ready_q;
   assign move_ack   = ack_q;
   assign move_err   = err_q;
   assign board      = board_q;
   assign turn       = turn_q;
   assign game_state = gs_q;
   assign win_line   = wl_q;

endmodule
